// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the serial BCD adder/subtractor.
interface bcd_serial_adder_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one decimal digit per clock, LSD first.
// Subtraction uses nines complement of b plus an inverted borrow as carry-in.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_serial_adder_if.slave   bus
);
  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       res_q, res_d;
  logic               sub_q, sub_d;
  logic               c_q, c_d;
  logic               err_l_q, err_l_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               err_q, err_d;

  logic               in_err_c;
  logic [3:0]         a_dig_c;
  logic [3:0]         b_dig_c;
  logic [3:0]         b_eff_c;
  logic [4:0]         t_c;
  logic [3:0]         r_dig_c;
  logic               carry_c;
  logic [W-1:0]       res_next_c;

  // Any operand digit above 9 poisons the whole operation.
  always_comb begin
    in_err_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
        in_err_c = 1'b1;
      end
    end
  end

  // Single-digit decimal add on the current least-significant digits.
  always_comb begin
    a_dig_c = a_q[3:0];
    b_dig_c = b_q[3:0];
    b_eff_c = sub_q ? 4'(4'd9 - b_dig_c) : b_dig_c;
    t_c     = 5'(a_dig_c) + 5'(b_eff_c) + 5'(c_q);
    if (t_c > 5'd9) begin
      r_dig_c = 4'(t_c + 5'd6);
      carry_c = 1'b1;
    end else begin
      r_dig_c = t_c[3:0];
      carry_c = 1'b0;
    end
    res_next_c = (res_q >> 4) | (W'(r_dig_c) << (W - 4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      err_l_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      err_l_q <= err_l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    c_d     = c_q;
    err_l_d = err_l_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          sub_d   = bus.sub;
          c_d     = bus.sub ? ~bus.cin : bus.cin;
          err_l_d = in_err_c;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = res_next_c;
        c_d   = carry_c;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          state_d = S_DONE;
          idx_d   = '0;
          done_d  = 1'b1;
          err_d   = err_l_q;
          sum_d   = err_l_q ? '0 : res_next_c;
          cout_d  = err_l_q ? 1'b0 : (sub_q ? ~carry_c : carry_c);
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for the serial BCD adder: directed plan, handshake corners, random
// 4-digit ops and an exhaustive 1-digit sweep against a decimal model.
module tb_bcd_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  bcd_serial_adder_if #(.DIGITS(4)) bus4 ();
  bcd_serial_adder_if #(.DIGITS(1)) bus1 ();

  bcd_serial_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  bcd_serial_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: operate on integer values, then re-encode as BCD.
  function automatic void model(input int n, input logic [15:0] a, input logic [15:0] b,
                                input logic sub, input logic cin,
                                output logic [15:0] s, output logic co, output logic er);
    int av, bv, r, m, d;
    av = 0; bv = 0; m = 1; er = 1'b0; s = '0; co = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'(a[4*i +: 4]); if (d > 9) er = 1'b1; av = av * 10 + d;
      d = int'(b[4*i +: 4]); if (d > 9) er = 1'b1; bv = bv * 10 + d;
      m = m * 10;
    end
    r = sub ? (av - bv - int'(cin)) : (av + bv + int'(cin));
    if (er) return;
    if (sub) begin
      co = (r < 0);
      if (r < 0) r = r + m;
    end else begin
      co = (r >= m);
      if (r >= m) r = r - m;
    end
    for (int i = 0; i < n; i++) begin
      s[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  function automatic logic [15:0] rand_bcd4(input bit allow_bad);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 4) == 0))
      v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Full 4-digit transaction with latency/busy-width/result checks.
  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic sub, input logic cin);
    logic [15:0] es;
    logic        eco, eer;
    int          edges, busy_n;
    model(4, a, b, sub, cin, es, eco, eer);
    @(negedge clk);
    bus4.a = a; bus4.b = b; bus4.sub = sub; bus4.cin = cin; bus4.start = 1'b1;
    @(posedge clk); #1;
    bus4.start = 1'b0;
    bus4.a = 16'($urandom); bus4.b = 16'($urandom); bus4.sub = ~sub; bus4.cin = ~cin;
    edges = 0; busy_n = 0;
    while (!bus4.done && edges < 20) begin
      if (bus4.busy) busy_n++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd4);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
    check({tag, " busy_at_done"}, 32'(bus4.busy), 32'd0);
    check({tag, " sum"}, 32'(bus4.sum), 32'(es));
    check({tag, " cout"}, 32'(bus4.cout), 32'(eco));
    check({tag, " err"}, 32'(bus4.err), 32'(eer));
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic sub, input logic cin);
    logic [15:0] es;
    logic        eco, eer;
    int          edges;
    model(1, 16'(a), 16'(b), sub, cin, es, eco, eer);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.sub = sub; bus1.cin = cin; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    edges = 0;
    while (!bus1.done && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check("d1 latency", 32'(edges), 32'd1);
    check("d1 sum", 32'(bus1.sum), 32'(es[3:0]));
    check("d1 cout", 32'(bus1.cout), 32'(eco));
    check("d1 digit_range", 32'(bus1.sum <= 4'd9), 32'd1);
  endtask

  initial begin
    int          edges, dones;
    logic [15:0] cap;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus4.start = 1'b0; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.a = '0; bus4.b = '0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.cin = 1'b0; bus1.a = '0; bus1.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(bus4.busy), 32'd0);
    check("rst done", 32'(bus4.done), 32'd0);
    check("rst sum", 32'(bus4.sum), 32'd0);
    check("rst cout_err", 32'({bus4.cout, bus4.err}), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed plan.
    op4("add_wrap",   16'h1234, 16'h8766, 1'b0, 1'b0);
    op4("add_cin",    16'h0999, 16'h0000, 1'b0, 1'b1);
    op4("sub_pos",    16'h0500, 16'h0123, 1'b1, 1'b0);
    op4("sub_neg",    16'h0100, 16'h0200, 1'b1, 1'b0);
    op4("sub_borrow", 16'h0000, 16'h0000, 1'b1, 1'b1);
    op4("bad_digit",  16'h12A4, 16'h0001, 1'b0, 1'b0);
    op4("add_max",    16'h9999, 16'h9999, 1'b0, 1'b1);

    // Restart request while RUN must be ignored.
    @(negedge clk);
    bus4.a = 16'h4321; bus4.b = 16'h1111; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1; bus4.start = 1'b0;
    @(posedge clk); #1;
    bus4.a = 16'h9999; bus4.b = 16'h9999; bus4.start = 1'b1;
    @(posedge clk); #1; bus4.start = 1'b0;
    dones = 0; cap = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.done) begin dones++; cap = bus4.sum; end
      @(posedge clk); #1;
    end
    check("midrun_start done_pulses", 32'(dones), 32'd1);
    check("midrun_start sum", 32'(cap), 32'h5432);

    // Start held high through DONE: second op begins without an IDLE cycle.
    @(negedge clk);
    bus4.a = 16'h2500; bus4.b = 16'h2500; bus4.sub = 1'b0; bus4.cin = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1;
    edges = 0;
    while (!bus4.done && edges < 20) begin @(posedge clk); #1; edges++; end
    check("b2b first sum", 32'(bus4.sum), 32'h5000);
    bus4.a = 16'h0001; bus4.b = 16'h0002; bus4.sub = 1'b1; bus4.cin = 1'b0;
    @(posedge clk); #1;
    check("b2b restart busy", 32'(bus4.busy), 32'd1);
    check("b2b restart done", 32'(bus4.done), 32'd0);
    bus4.start = 1'b0;
    edges = 0;
    while (!bus4.done && edges < 20) begin @(posedge clk); #1; edges++; end
    check("b2b second latency", 32'(edges), 32'd4);
    check("b2b second sum", 32'(bus4.sum), 32'h9999);
    check("b2b second cout", 32'(bus4.cout), 32'd1);

    // Asynchronous reset mid-RUN clears everything and suppresses done.
    @(negedge clk);
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.sub = 1'b0; bus4.start = 1'b1;
    @(posedge clk); #1; bus4.start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst busy", 32'(bus4.busy), 32'd0);
    check("midrun_rst done", 32'(bus4.done), 32'd0);
    check("midrun_rst sum", 32'(bus4.sum), 32'd0);
    check("midrun_rst cout", 32'(bus4.cout), 32'd0);
    check("midrun_rst err", 32'(bus4.err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus4.done || bus4.busy) dones++;
    end
    check("midrun_rst no_activity", 32'(dones), 32'd0);

    // Randomized 4-digit operations, occasionally with an invalid digit.
    for (int i = 0; i < 40; i++) begin
      op4("rand", rand_bcd4(1'b1), rand_bcd4(1'b1), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
    end

    // Exhaustive single-digit sweep.
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int a = 0; a < 10; a++)
          for (int b = 0; b < 10; b++)
            op1(4'(a), 4'(b), 1'(s), 1'(c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
